pic_cycle_sequencer: RTL and testbench

Generates the four-clock Q1..Q4 instruction-cycle phasing for the PIC16F core and sequences fetch, PC update and execute qualification around the instruction decoder. It overlaps fetch of instruction N+1 with execution of instruction N. It inserts forced-NOP cycles for pipeline fill, taken branches and skips, so that ordinary instructions cost 4 clocks and branches cost 8. It also implements the SLEEP hold/wake sequencing.

---
 rtl/pic_core_pkg.sv | 21 ++
 rtl/pic_q_counter.sv | 48 ++++
 rtl/pic_cycle_sequencer.sv | 123 ++++++++++++
 tb/tb_pic_cycle_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pic_core_pkg.sv
// Shared encodings for the PIC16F core: Q-phase values, sequencer states, cycle length.
package pic_core_pkg;

  // Clocks per instruction cycle.
  localparam int unsigned CycleLen = 4;
  localparam int unsigned PhaseW   = $clog2(CycleLen);

  typedef enum logic [PhaseW-1:0] {
    PhQ1 = 2'd0,
    PhQ2 = 2'd1,
    PhQ3 = 2'd2,
    PhQ4 = 2'd3
  } phase_e;

  typedef enum logic [1:0] {
    StFill  = 2'd0,
    StRun   = 2'd1,
    StSleep = 2'd2
  } seq_state_e;

endpackage

// File: rtl/pic_q_counter.sv
// Free-running Q1..Q4 phase counter with clock enable and hold, plus one-hot phase strobes.
module pic_q_counter
  import pic_core_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              hold,
  output logic [PhaseW-1:0] q,
  output logic              q1_stb,
  output logic              q2_stb,
  output logic              q3_stb,
  output logic              q4_stb
);

  logic [PhaseW-1:0] q_q;
  logic [PhaseW-1:0] q_d;
  logic              stb_gate;

  // Next phase: advance mod CycleLen only when enabled and not held.
  always_comb begin
    q_d = q_q;
    if (en && !hold) begin
      q_d = q_q + PhaseW'(1);
    end
  end

  // Phase register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= PhaseW'(PhQ1);
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

  // Strobes read low while in reset, frozen or held.
  always_comb begin
    stb_gate = en && !hold && !rst;
    q1_stb   = stb_gate && (q_q == PhQ1);
    q2_stb   = stb_gate && (q_q == PhQ2);
    q3_stb   = stb_gate && (q_q == PhQ3);
    q4_stb   = stb_gate && (q_q == PhQ4);
  end

endmodule

// File: rtl/pic_cycle_sequencer.sv
// PIC16F instruction-cycle sequencer: Q-phasing, fetch/PC strobes, forced-NOP insertion, SLEEP.
module pic_cycle_sequencer
  import pic_core_pkg::*;
#(
  parameter int unsigned FILL_CYCLES = 1,
  parameter int unsigned FILL_W      = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       branch_taken,
  input  logic       skip_req,
  input  logic       sleep_req,
  input  logic       wake,
  output logic [1:0] q,
  output logic       q1_stb,
  output logic       q2_stb,
  output logic       q3_stb,
  output logic       q4_stb,
  output logic       instr_rd_en,
  output logic       incr_pc_en,
  output logic       pc_load_en,
  output logic       exec_valid,
  output logic       sleeping
);

  localparam logic [FILL_W-1:0] FillLast = FILL_W'(FILL_CYCLES - 1);

  seq_state_e        state_q, state_d;
  logic              exec_valid_q, exec_valid_d;
  logic [FILL_W-1:0] fill_cnt_q, fill_cnt_d;
  logic              q4_edge;
  logic              load_now;

  assign sleeping   = (state_q == StSleep);
  assign exec_valid = exec_valid_q;

  pic_q_counter u_q_counter (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .hold   (sleeping),
    .q      (q),
    .q1_stb (q1_stb),
    .q2_stb (q2_stb),
    .q3_stb (q3_stb),
    .q4_stb (q4_stb)
  );

  // Next-state: exec qualification is decided only on the Q4 edge; wake may come at any edge.
  always_comb begin
    state_d      = state_q;
    exec_valid_d = exec_valid_q;
    fill_cnt_d   = fill_cnt_q;
    q4_edge      = en && (q == PhQ4) && (state_q != StSleep);
    unique case (state_q)
      StFill: begin
        if (q4_edge) begin
          if (fill_cnt_q == FillLast) begin
            state_d      = StRun;
            exec_valid_d = 1'b1;
          end else begin
            fill_cnt_d   = fill_cnt_q + FILL_W'(1);
            exec_valid_d = 1'b0;
          end
        end
      end
      StRun: begin
        if (q4_edge) begin
          // A forced NOP never branches, skips or sleeps; branch > skip > sleep.
          if (exec_valid_q && branch_taken) begin
            exec_valid_d = 1'b0;
          end else if (exec_valid_q && skip_req) begin
            exec_valid_d = 1'b0;
          end else if (exec_valid_q && sleep_req) begin
            state_d      = StSleep;
            exec_valid_d = 1'b0;
          end else begin
            exec_valid_d = 1'b1;
          end
        end
      end
      StSleep: begin
        // The word prefetched before SLEEP executes on wake.
        if (en && wake) begin
          state_d      = StRun;
          exec_valid_d = 1'b1;
        end
      end
      default: begin
        state_d      = StFill;
        exec_valid_d = 1'b0;
      end
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StFill;
      exec_valid_q <= 1'b0;
      fill_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      exec_valid_q <= exec_valid_d;
      fill_cnt_q   <= fill_cnt_d;
    end
  end

  // Fetch/PC strobes: every Q4 outside SLEEP fetches at the pre-update PC.
  always_comb begin
    instr_rd_en = 1'b0;
    incr_pc_en  = 1'b0;
    pc_load_en  = 1'b0;
    load_now    = exec_valid_q && branch_taken && (state_q == StRun);
    if (q4_edge && !rst) begin
      instr_rd_en = 1'b1;
      pc_load_en  = load_now;
      incr_pc_en  = !load_now;
    end
  end

endmodule

// File: tb/tb_pic_cycle_sequencer.sv
// Directed self-checking bench for pic_cycle_sequencer (FILL_CYCLES = 1).
`timescale 1ns/1ps
module tb_pic_cycle_sequencer;

  logic       clk = 1'b0;
  logic       rst, en, branch_taken, skip_req, sleep_req, wake;
  logic [1:0] q;
  logic       q1_stb, q2_stb, q3_stb, q4_stb;
  logic       instr_rd_en, incr_pc_en, pc_load_en, exec_valid, sleeping;

  int checks = 0;
  int errors = 0;

  pic_cycle_sequencer #(
    .FILL_CYCLES (1),
    .FILL_W      (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .branch_taken (branch_taken),
    .skip_req     (skip_req),
    .sleep_req    (sleep_req),
    .wake         (wake),
    .q            (q),
    .q1_stb       (q1_stb),
    .q2_stb       (q2_stb),
    .q3_stb       (q3_stb),
    .q4_stb       (q4_stb),
    .instr_rd_en  (instr_rd_en),
    .incr_pc_en   (incr_pc_en),
    .pc_load_en   (pc_load_en),
    .exec_valid   (exec_valid),
    .sleeping     (sleeping)
  );

  always #5 clk = ~clk;

  // Advance one clock and sample 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Step until q reaches the target phase, bounded.
  task automatic goto_q(input logic [1:0] t);
    int n = 0;
    while (q !== t && n < 8) begin
      step();
      n++;
    end
    checks++;
    if (q !== t) begin
      errors++;
      $display("FAIL goto_q: q=%0d required %0d", q, t);
    end
  endtask

  task automatic test_reset();
    logic [1:0] ph;
    rst = 1'b1; en = 1'b1; branch_taken = 1'b0; skip_req = 1'b0; sleep_req = 1'b0; wake = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({q, exec_valid, sleeping} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_state: q=%0d ev=%0b slp=%0b required 0 0 0", q, exec_valid, sleeping);
    end
    checks++;
    if ({q1_stb, q2_stb, q3_stb, q4_stb, instr_rd_en, incr_pc_en, pc_load_en} !== 7'b0) begin
      errors++;
      $display("FAIL reset_strobes: %b required 0000000",
               {q1_stb, q2_stb, q3_stb, q4_stb, instr_rd_en, incr_pc_en, pc_load_en});
    end
    rst = 1'b0;
    #1;
    // Period n follows the n-th edge after release.
    for (int n = 0; n < 12; n++) begin
      ph = 2'(n % 4);
      checks++;
      if (q !== ph || exec_valid !== (n >= 4) || instr_rd_en !== (ph == 2'd3) ||
          incr_pc_en !== (ph == 2'd3) || pc_load_en !== 1'b0) begin
        errors++;
        $display("FAIL fill_seq[%0d]: q=%0d ev=%0b rd=%0b inc=%0b ld=%0b required %0d %0b %0b %0b 0",
                 n, q, exec_valid, instr_rd_en, incr_pc_en, pc_load_en,
                 ph, (n >= 4), (ph == 2'd3), (ph == 2'd3));
      end
      checks++;
      if ({q1_stb, q2_stb, q3_stb, q4_stb} !== (4'b1000 >> ph)) begin
        errors++;
        $display("FAIL strobe[%0d]: %b required %b", n, {q1_stb, q2_stb, q3_stb, q4_stb},
                 (4'b1000 >> ph));
      end
      step();
    end
  endtask

  task automatic test_branch();
    goto_q(2'd3);
    branch_taken = 1'b1;
    #1;
    checks++;
    if (pc_load_en !== 1'b1 || incr_pc_en !== 1'b0 || instr_rd_en !== 1'b1) begin
      errors++;
      $display("FAIL branch_pc: ld=%0b inc=%0b rd=%0b required 1 0 1",
               pc_load_en, incr_pc_en, instr_rd_en);
    end
    step();
    branch_taken = 1'b0;
    for (int n = 0; n < 4; n++) begin
      checks++;
      if (exec_valid !== 1'b0) begin
        errors++;
        $display("FAIL branch_nop[%0d]: ev=%0b required 0", n, exec_valid);
      end
      if (n < 3) step();
    end
    checks++;
    if (incr_pc_en !== 1'b1 || pc_load_en !== 1'b0) begin
      errors++;
      $display("FAIL branch_nop_fetch: inc=%0b ld=%0b required 1 0", incr_pc_en, pc_load_en);
    end
    step();
    checks++;
    if (exec_valid !== 1'b1 || q !== 2'd0) begin
      errors++;
      $display("FAIL branch_target: ev=%0b q=%0d required 1 0", exec_valid, q);
    end
  endtask

  task automatic test_skip();
    goto_q(2'd3);
    skip_req = 1'b1;
    #1;
    checks++;
    if (incr_pc_en !== 1'b1 || pc_load_en !== 1'b0) begin
      errors++;
      $display("FAIL skip_pc: inc=%0b ld=%0b required 1 0", incr_pc_en, pc_load_en);
    end
    step();
    skip_req = 1'b0;
    checks++;
    if (exec_valid !== 1'b0) begin
      errors++;
      $display("FAIL skip_nop: ev=%0b required 0", exec_valid);
    end
    repeat (4) step();
    checks++;
    if (exec_valid !== 1'b1) begin
      errors++;
      $display("FAIL skip_after: ev=%0b required 1", exec_valid);
    end
  endtask

  task automatic test_nop_branch();
    // Make a NOP cycle with a skip, then branch inside it.
    goto_q(2'd3);
    skip_req = 1'b1;
    step();
    skip_req = 1'b0;
    goto_q(2'd3);
    branch_taken = 1'b1;
    #1;
    checks++;
    if (exec_valid !== 1'b0 || pc_load_en !== 1'b0 || incr_pc_en !== 1'b1) begin
      errors++;
      $display("FAIL nop_branch: ev=%0b ld=%0b inc=%0b required 0 0 1",
               exec_valid, pc_load_en, incr_pc_en);
    end
    step();
    branch_taken = 1'b0;
    checks++;
    if (exec_valid !== 1'b1) begin
      errors++;
      $display("FAIL nop_branch_next: ev=%0b required 1", exec_valid);
    end
    // Branch and skip together on a valid cycle: branch wins.
    goto_q(2'd3);
    branch_taken = 1'b1;
    skip_req     = 1'b1;
    #1;
    checks++;
    if (pc_load_en !== 1'b1 || incr_pc_en !== 1'b0) begin
      errors++;
      $display("FAIL branch_skip_prio: ld=%0b inc=%0b required 1 0", pc_load_en, incr_pc_en);
    end
    step();
    branch_taken = 1'b0;
    skip_req     = 1'b0;
    repeat (4) step();
    checks++;
    if (exec_valid !== 1'b1) begin
      errors++;
      $display("FAIL branch_skip_after: ev=%0b required 1", exec_valid);
    end
  endtask

  task automatic test_sleep();
    goto_q(2'd3);
    sleep_req = 1'b1;
    #1;
    checks++;
    if (instr_rd_en !== 1'b1 || incr_pc_en !== 1'b1 || pc_load_en !== 1'b0) begin
      errors++;
      $display("FAIL sleep_fetch: rd=%0b inc=%0b ld=%0b required 1 1 0",
               instr_rd_en, incr_pc_en, pc_load_en);
    end
    step();
    sleep_req = 1'b0;
    for (int n = 0; n < 20; n++) begin
      checks++;
      if (sleeping !== 1'b1 || q !== 2'd0 || exec_valid !== 1'b0 ||
          {q1_stb, q2_stb, q3_stb, q4_stb, instr_rd_en, incr_pc_en, pc_load_en} !== 7'b0) begin
        errors++;
        $display("FAIL sleep_hold[%0d]: slp=%0b q=%0d ev=%0b outs=%b required 1 0 0 0000000",
                 n, sleeping, q, exec_valid,
                 {q1_stb, q2_stb, q3_stb, q4_stb, instr_rd_en, incr_pc_en, pc_load_en});
      end
      step();
    end
    // Wake is ignored while frozen.
    en   = 1'b0;
    wake = 1'b1;
    step();
    step();
    checks++;
    if (sleeping !== 1'b1) begin
      errors++;
      $display("FAIL sleep_en_off_wake: slp=%0b required 1", sleeping);
    end
    en = 1'b1;
    step();
    wake = 1'b0;
    checks++;
    if (sleeping !== 1'b0 || q1_stb !== 1'b1 || exec_valid !== 1'b1 || q !== 2'd0) begin
      errors++;
      $display("FAIL wake: slp=%0b q1=%0b ev=%0b q=%0d required 0 1 1 0",
               sleeping, q1_stb, exec_valid, q);
    end
  endtask

  task automatic test_en_freeze();
    goto_q(2'd1);
    en = 1'b0;
    for (int n = 0; n < 3; n++) begin
      #1;
      checks++;
      if (q !== 2'd1 || {q1_stb, q2_stb, q3_stb, q4_stb} !== 4'b0) begin
        errors++;
        $display("FAIL en_freeze[%0d]: q=%0d stb=%b required 1 0000", n, q,
                 {q1_stb, q2_stb, q3_stb, q4_stb});
      end
      step();
    end
    en = 1'b1;
    #1;
    checks++;
    if (q2_stb !== 1'b1 || q !== 2'd1) begin
      errors++;
      $display("FAIL en_resume: q2=%0b q=%0d required 1 1", q2_stb, q);
    end
    step();
    checks++;
    if (q !== 2'd2) begin
      errors++;
      $display("FAIL en_advance: q=%0d required 2", q);
    end
  endtask

  task automatic test_reset_mid();
    goto_q(2'd2);
    branch_taken = 1'b1;
    rst = 1'b1;
    #1;
    checks++;
    if (q !== 2'd0 || exec_valid !== 1'b0 || pc_load_en !== 1'b0 || q1_stb !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: q=%0d ev=%0b ld=%0b q1=%0b required 0 0 0 0",
               q, exec_valid, pc_load_en, q1_stb);
    end
    step();
    rst = 1'b0;
    #1;
    for (int n = 0; n < 4; n++) begin
      checks++;
      if (pc_load_en !== 1'b0 || exec_valid !== 1'b0 || q !== 2'(n)) begin
        errors++;
        $display("FAIL reset_mid_fill[%0d]: ld=%0b ev=%0b q=%0d required 0 0 %0d",
                 n, pc_load_en, exec_valid, q, n);
      end
      step();
    end
    branch_taken = 1'b0;
    checks++;
    if (exec_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_run: ev=%0b required 1", exec_valid);
    end
  endtask

  initial begin
    test_reset();
    test_branch();
    test_skip();
    test_nop_branch();
    test_sleep();
    test_en_freeze();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time bound in case a wait misbehaves.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
